// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, register-index width
// and the stage-register ld/flush bundle.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MEM_DONE = 2'd2
  } state_e;

  // Order of the stage-register controls, PC first down to MEM/WB.
  typedef struct packed {
    logic pc_ld;
    logic if_id_ld;
    logic if_id_flush;
    logic id_ex_ld;
    logic id_ex_flush;
    logic ex_mem_ld;
    logic mem_wb_ld;
  } ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath/SRAM-facing signal bundle of the hazard controller.
// master = controller side, slave = datapath/SRAM side.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import pipe_hazard_ctrl_pkg::*;

  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic [REG_W-1:0] exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [REG_W-1:0] mem_dest;
  logic             mem_wb_en;
  logic             mem_op;
  logic             br_taken;
  logic             sram_ready;
  logic             sram_req;
  logic             pc_ld;
  logic             if_id_ld;
  logic             if_id_flush;
  logic             id_ex_ld;
  logic             id_ex_flush;
  logic             ex_mem_ld;
  logic             mem_wb_ld;
  logic             bus_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, mem_op, br_taken, sram_ready,
    output sram_req, pc_ld, if_id_ld, if_id_flush, id_ex_ld, id_ex_flush,
           ex_mem_ld, mem_wb_ld, bus_err, stall_cnt, flush_cnt
  );

  modport slave (
    output id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, mem_op, br_taken, sram_ready,
    input  sram_req, pc_ld, if_id_ld, if_id_flush, id_ex_ld, id_ex_flush,
           ex_mem_ld, mem_wb_ld, bus_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW detector for the instruction in ID against EXE/MEM destinations.
// With forwarding only a load in EXE can stall; without it any pending writeback does.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b0
) (
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             hazard_c
);

  logic exe_match;
  logic mem_match;
  logic raw_any;
  logic load_use;

  always_comb begin
    exe_match = (src1 == exe_dest) || (two_src && (src2 == exe_dest));
    mem_match = (src1 == mem_dest) || (two_src && (src2 == mem_dest));
    raw_any   = (exe_wb_en && exe_match) || (mem_wb_en && mem_match);
    load_use  = exe_mem_r_en && exe_match;
    hazard_c  = FWD_EN ? load_use : raw_any;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: per-stage ld/flush, PC load, SRAM request FSM with timeout,
// sticky bus error and saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit          FWD_EN  = 1'b0,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input logic                clk,
  input logic                rst_n,
  pipe_hazard_ctrl_if.master bus
);

  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e             state_q,     state_d;
  logic [WAIT_W-1:0]  wait_cnt_q,  wait_cnt_d;
  logic               sram_req_q,  sram_req_d;
  logic               bus_err_q,   bus_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               hazard_c;
  logic               frozen_c;
  ctrl_t              ctrl_c;
  ctrl_t              ctrl_out_c;

  pipe_hazard_ctrl_hazard_detect #(.FWD_EN(FWD_EN)) u_hazard_detect (
    .src1         (bus.id_src1),
    .src2         (bus.id_src2),
    .two_src      (bus.id_two_src),
    .exe_dest     (bus.exe_dest),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_mem_r_en (bus.exe_mem_r_en),
    .mem_dest     (bus.mem_dest),
    .mem_wb_en    (bus.mem_wb_en),
    .hazard_c     (hazard_c)
  );

  // Next state, stage controls and counter updates.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    bus_err_d   = bus_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    frozen_c    = 1'b0;
    ctrl_c      = '0;

    unique case (state_q)
      ST_RUN: begin
        if (bus.mem_op) begin
          frozen_c   = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        frozen_c = 1'b1;
        if (bus.sram_ready) begin
          state_d    = ST_MEM_DONE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_MEM_DONE;
          wait_cnt_d = '0;
          bus_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_MEM_DONE: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase

    if (frozen_c) begin
      if (~&stall_cnt_q) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (bus.br_taken) begin
      ctrl_c = '{pc_ld: 1'b1, if_id_ld: 1'b1, if_id_flush: 1'b1, id_ex_ld: 1'b1,
                 id_ex_flush: 1'b1, ex_mem_ld: 1'b1, mem_wb_ld: 1'b1};
      if (~&flush_cnt_q) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (hazard_c) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX, let older stages drain.
      ctrl_c = '{pc_ld: 1'b0, if_id_ld: 1'b0, if_id_flush: 1'b0, id_ex_ld: 1'b1,
                 id_ex_flush: 1'b1, ex_mem_ld: 1'b1, mem_wb_ld: 1'b1};
      if (~&stall_cnt_q) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      ctrl_c = '{pc_ld: 1'b1, if_id_ld: 1'b1, if_id_flush: 1'b0, id_ex_ld: 1'b1,
                 id_ex_flush: 1'b0, ex_mem_ld: 1'b1, mem_wb_ld: 1'b1};
    end

    sram_req_d = (state_d == ST_MEM_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      sram_req_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      sram_req_q  <= sram_req_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Stage registers must not load or flush while reset is asserted.
  assign ctrl_out_c = rst_n ? ctrl_c : '0;

  assign bus.pc_ld       = ctrl_out_c.pc_ld;
  assign bus.if_id_ld    = ctrl_out_c.if_id_ld;
  assign bus.if_id_flush = ctrl_out_c.if_id_flush;
  assign bus.id_ex_ld    = ctrl_out_c.id_ex_ld;
  assign bus.id_ex_flush = ctrl_out_c.id_ex_flush;
  assign bus.ex_mem_ld   = ctrl_out_c.ex_mem_ld;
  assign bus.mem_wb_ld   = ctrl_out_c.mem_wb_ld;
  assign bus.sram_req    = sram_req_q;
  assign bus.bus_err     = bus_err_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule
